// File: rtl/lcd_bus_driver_if.sv
// lcd_bus_driver_if: item handshake from sequencer (in_valid/in_rs/in_data in, in_ready back)
interface lcd_bus_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  modport master (output in_valid, in_rs, in_data, input in_ready);
  modport slave (input in_valid, in_rs, in_data, output in_ready);
endinterface

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 8-bit bus timing; ports clk, rst, bus (item handshake), init_done, LCD_data/en/rw/rs/blon
module lcd_bus_driver #(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 12,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000
) (
  input  logic             clk,
  input  logic             rst,
  lcd_bus_driver_if.slave  bus,
  output logic             init_done,
  output logic [7:0]       LCD_data,
  output logic             LCD_en,
  output logic             LCD_rw,
  output logic             LCD_rs,
  output logic             LCD_blon
);
  typedef enum logic [2:0] {PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE} state_t;
  localparam logic [19:0] L_PWR    = 20'(POWERUP_CYC - 1);
  localparam logic [19:0] L_SETUP  = 20'(SETUP_CYC - 1);
  localparam logic [19:0] L_SETUP2 = 20'(SETUP_CYC > 1 ? SETUP_CYC - 2 : 0);
  localparam logic [19:0] L_PULSE  = 20'(PULSE_CYC - 1);
  localparam logic [19:0] L_HOLD   = 20'(HOLD_CYC - 1);
  localparam logic [19:0] L_EXEC   = 20'(EXEC_CYC - 1);
  localparam logic [19:0] L_CLEAR  = 20'(CLEAR_CYC - 1);
  state_t      r_state;
  logic [19:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_done, r_en, r_rs, r_blon, r_ready;
  logic [7:0]  r_data;
  logic        w_zero, w_clear;
  logic [7:0]  w_init_byte;
  assign w_zero      = r_cnt == 20'd0;
  assign w_clear     = !r_rs && r_data[7:2] == 6'd0 && r_data[1:0] != 2'd0;
  assign w_init_byte = r_idx == 2'd0 ? 8'h38 : r_idx == 2'd1 ? 8'h0C : r_idx == 2'd2 ? 8'h01 : 8'h06;
  assign bus.in_ready = r_ready;
  assign init_done    = r_done;
  assign LCD_data     = r_data;
  assign LCD_en       = r_en;
  assign LCD_rw       = 1'b0;
  assign LCD_rs       = r_rs;
  assign LCD_blon     = r_blon;
  // The cycle spent in INIT_LOAD already presents the init byte on the pins,
  // so it counts as the first setup cycle of that write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PWRUP;
      r_cnt   <= L_PWR;
      r_idx   <= 2'd0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_blon  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_blon <= 1'b1;
      r_cnt  <= w_zero ? r_cnt : r_cnt - 20'd1;
      case (r_state)
        PWRUP: if (w_zero) begin
          r_state <= INIT_LOAD;
          r_rs    <= 1'b0;
          r_data  <= w_init_byte;
          r_idx   <= r_idx + 2'd1;
        end
        INIT_LOAD: if (SETUP_CYC == 1) begin
          r_state <= PULSE;
          r_en    <= 1'b1;
          r_cnt   <= L_PULSE;
        end else begin
          r_state <= SETUP;
          r_cnt   <= L_SETUP2;
        end
        SETUP: if (w_zero) begin
          r_state <= PULSE;
          r_en    <= 1'b1;
          r_cnt   <= L_PULSE;
        end
        PULSE: if (w_zero) begin
          r_state <= HOLD;
          r_en    <= 1'b0;
          r_cnt   <= L_HOLD;
        end
        HOLD: if (w_zero) begin
          r_state <= EXEC;
          r_cnt   <= w_clear ? L_CLEAR : L_EXEC;
        end
        // r_idx wraps to 0 once all four init bytes have been loaded
        EXEC: if (w_zero) begin
          if (!r_done && r_idx != 2'd0) begin
            r_state <= INIT_LOAD;
            r_rs    <= 1'b0;
            r_data  <= w_init_byte;
            r_idx   <= r_idx + 2'd1;
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        IDLE: if (bus.in_valid) begin
          r_state <= SETUP;
          r_rs    <= bus.in_rs;
          r_data  <= bus.in_data;
          r_cnt   <= L_SETUP;
          r_ready <= 1'b0;
        end
        default: r_state <= PWRUP;
      endcase
    end
  end
endmodule
